// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: power-on init sweep of R1..R31, then
// round-robin arbitration of NREQ writeback requesters, with R0 writes squashed.
module regfile_wb_arbiter #(
  parameter int                 NREQ     = 3,
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter int                 SP_ADDR  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT  = DATA_W'(252)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       init_busy,
  output logic                       init_done,
  output logic                       drop_r0
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {S_RST, S_INIT, S_ARB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;
  logic                init_busy_q, init_busy_d;
  logic                init_done_q, init_done_d;
  logic                drop_r0_q, drop_r0_d;

  logic                arb_en;
  logic                grant_vld;
  logic [GW-1:0]       sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  int                  rr_idx;

  // Arbitration waits for the sweep's last write to retire, so the init_done
  // cycle is always write-free; reset also blocks any handshake.
  assign arb_en = (state_q == S_ARB) && !init_busy_q && !nrst;

  always_comb begin
    grant_vld = 1'b0;
    sel       = '0;
    rr_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = int'(last_grant_q) + 1 + k;
      if (rr_idx >= NREQ) rr_idx -= NREQ;
      if (!grant_vld && arb_en && req_valid[GW'(rr_idx)]) begin
        grant_vld = 1'b1;
        sel       = GW'(rr_idx);
      end
    end
  end

  assign req_ready = grant_vld ? (NREQ'(1) << sel) : '0;
  assign sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(sel)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= S_RST;
      init_ptr_q   <= ADDR_W'(1);
      last_grant_q <= GW'(NREQ - 1);
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= '0;
      init_busy_q  <= 1'b1;
      init_done_q  <= 1'b0;
      drop_r0_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
      init_busy_q  <= init_busy_d;
      init_done_q  <= init_done_d;
      drop_r0_q    <= drop_r0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_INIT;
      S_INIT:  if (init_ptr_q == '1) state_d = S_ARB;
      S_ARB:   state_d = S_ARB;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    init_ptr_d   = init_ptr_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    grant_id_d   = grant_id_q;
    init_busy_d  = init_busy_q;
    init_done_d  = 1'b0;
    drop_r0_d    = 1'b0;
    case (state_q)
      S_RST: begin
        init_ptr_d  = ADDR_W'(1);
        init_busy_d = 1'b1;
      end
      S_INIT: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = init_ptr_q;
        wr_data_d   = (init_ptr_q == ADDR_W'(SP_ADDR)) ? SP_INIT : INIT_VAL;
        grant_id_d  = '0;
        init_ptr_d  = init_ptr_q + 1'b1;
        init_busy_d = 1'b1;
      end
      S_ARB: begin
        init_busy_d = 1'b0;
        init_done_d = init_busy_q;
        if (grant_vld) begin
          last_grant_d = sel;
          grant_id_d   = sel;
          // R0 is hard-wired zero: consume the request but never write it.
          if (sel_addr == '0) begin
            drop_r0_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;
  assign init_busy = init_busy_q;
  assign init_done = init_done_q;
  assign drop_r0   = drop_r0_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a driver pushes expected writes,
// a negedge monitor pops and compares whenever a write or R0 drop appears.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                 clk;
  logic                 nrst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [1:0]           grant_id;
  logic                 init_busy;
  logic                 init_done;
  logic                 drop_r0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .init_busy(init_busy),
    .init_done(init_done), .drop_r0(drop_r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   last_m;
  int   wait_c[NREQ];

  logic [NREQ-1:0]    pend;
  logic [NREQ*AW-1:0] pa;
  logic [NREQ*DW-1:0] pd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Round-robin reference: first valid requester after the last one served.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (last + 1 + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (wr_en || drop_r0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {62'd0, wr_en, drop_r0}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.addr == '0) begin
          chk("drop_r0", drop_r0, 1);
          chk("drop_wr_en", wr_en, 0);
          chk("drop_gid", grant_id, mon_e.gid);
        end else begin
          chk("wr_en", wr_en, 1);
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
          chk("grant_id", grant_id, mon_e.gid);
          chk("no_drop", drop_r0, 0);
        end
      end
    end
  end

  task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                             input logic [NREQ*DW-1:0] d, output int win);
    logic [NREQ-1:0] expr;
    exp_t e;
    int worst;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #2;
    win  = rr_pick(v, last_m);
    expr = '0;
    if (win >= 0) expr[win] = 1'b1;
    chk("req_ready", req_ready, expr);
    if (win >= 0) begin
      e.addr = a[win*AW +: AW];
      e.data = d[win*DW +: DW];
      e.gid  = win;
      exp_q.push_back(e);
      last_m = win;
    end
    worst = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && i != win) wait_c[i]++;
      else wait_c[i] = 0;
      if (wait_c[i] > worst) worst = wait_c[i];
    end
    chk("fairness", worst >= NREQ, 0);
    @(posedge clk); #1;
  endtask

  task automatic full_sweep();
    exp_t e;
    int done_at;
    done_at = -1;
    for (int a = 1; a < 32; a++) begin
      e.addr = AW'(a);
      e.data = (a == 29) ? 32'd252 : 32'd0;
      e.gid  = 0;
      exp_q.push_back(e);
    end
    req_valid = '1;
    req_addr  = {$urandom, $urandom} | 15'h0421;
    req_data  = {$urandom, $urandom, $urandom};
    nrst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (init_done) begin
        done_at = c;
        break;
      end
      chk("init_ready", req_ready, 0);
      chk("init_busy", init_busy, 1);
    end
    req_valid = '0;
    chk("init_done_cycle", done_at, 33);
    chk("post_busy", init_busy, 0);
    chk("post_wr_en", wr_en, 0);
    chk("sweep_q_empty", exp_q.size(), 0);
    last_m = NREQ - 1;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    pend = '0;
    @(posedge clk); #1;
    chk("done_pulse_once", init_done, 0);
  endtask

  task automatic partial_sweep(input int stop);
    exp_t e;
    for (int a = 1; a <= stop; a++) begin
      e.addr = AW'(a);
      e.data = 32'd0;
      e.gid  = 0;
      exp_q.push_back(e);
    end
    req_valid = '1;
    nrst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (wr_en && wr_addr == AW'(stop)) break;
      chk("abort_init_ready", req_ready, 0);
    end
    chk("abort_point", wr_addr, stop);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", init_busy, 1);
  endtask

  task automatic random_phase(input int n);
    int w;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          pa[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i*DW +: DW] = $urandom;
        end
      end
      drive_cycle(pend, pa, pd, w);
      if (w >= 0) pend[w] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    nrst      = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    pend      = '0;
    pa        = '0;
    pd        = '0;
    last_m    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;

    @(posedge clk); #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_done", init_done, 0);
    chk("rst_drop", drop_r0, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1;

    partial_sweep(10);
    full_sweep();

    // single request from requester 0
    a = '0; d = '0;
    a[4:0] = 5'd5; d[31:0] = 32'hDEADBEEF;
    drive_cycle(3'b001, a, d, w);
    chk("single_win", w, 0);
    drive_cycle(3'b000, a, d, w);

    // all requesters held valid: strict rotation after requester 0
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i*AW +: AW] = 5'($urandom_range(1, 31));
        d[i*DW +: DW] = $urandom;
      end
      drive_cycle(3'b111, a, d, w);
      chk("rr_seq", w, (k + 1) % 3);
    end

    // R0 target from requester 1, requester 2 also waiting
    a = '0; d = '0;
    a[1*AW +: AW] = 5'd0;  d[1*DW +: DW] = 32'h1234;
    a[2*AW +: AW] = 5'd7;  d[2*DW +: DW] = 32'hA5A5_0007;
    drive_cycle(3'b110, a, d, w);
    chk("r0_win", w, 1);
    drive_cycle(3'b100, a, d, w);
    chk("after_r0_win", w, 2);
    drive_cycle(3'b000, a, d, w);

    // requester 2 steady while 0 and 1 toggle
    a[2*AW +: AW] = 5'd19; d[2*DW +: DW] = 32'h0BAD_F00D;
    a[0 +: AW] = 5'd3; a[AW +: AW] = 5'd4;
    begin
      int acc_at;
      acc_at = -1;
      for (int c = 0; c < 6; c++) begin
        drive_cycle({1'b1, (c % 2) == 1, (c % 2) == 0}, a, d, w);
        if (w == 2) begin
          acc_at = c;
          break;
        end
      end
      chk("req2_within_3", (acc_at >= 0) && (acc_at < 3), 1);
    end
    drive_cycle(3'b000, a, d, w);

    random_phase(300);

    // reset in the middle of arbitration squashes the pending handshake
    req_valid = '1;
    req_addr  = {5'd9, 5'd10, 5'd11};
    nrst = 1'b1;
    #2;
    chk("arb_rst_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("arb_rst_wr_en", wr_en, 0);
    chk("arb_rst_busy", init_busy, 1);
    full_sweep();

    random_phase(100);
    for (int c = 0; c < 4; c++) drive_cycle(3'b000, pa, pd, w);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
